// File: rtl/ringosc_freq_meter.sv
// Ring-oscillator frequency meter.
// Drives the oscillator counter macro through clear / run / stop phases.
// Widens its 8-bit count with an MSB wrap counter and publishes one
// {wraps, count} result per accepted start request.
module ringosc_freq_meter #(
    parameter int WINDOW_W   = 16,
    parameter int EXT_W      = 8,
    parameter int CLR_CYCLES = 2,
    parameter int SETTLE     = 4
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [WINDOW_W-1:0] window_i,
    input  logic [7:0]          cnt_i,
    output logic                osc_reset_o,
    output logic                osc_stop_o,
    output logic                busy_o,
    output logic                valid_o,
    output logic [EXT_W+7:0]    result_o,
    output logic                overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_STOP,
        S_CAPTURE
    } state_t;

    // Phase timers count down to zero, so each phase loads length-1.
    // The stop phase also absorbs the two synchroniser stages.
    localparam logic [WINDOW_W-1:0] CLR_LOAD  = WINDOW_W'(CLR_CYCLES - 1);
    localparam logic [WINDOW_W-1:0] STOP_LOAD = WINDOW_W'(SETTLE + 1);
    // Index of the final allowed capture mismatch (8 in total).
    localparam logic [3:0]          MISS_LAST = 4'd7;

    // ------------------------------------------------------------------
    // Two-flop synchroniser per count bit. Only bit 7 is trusted while the
    // oscillator runs; the full word is used only once it is stopped.
    // ------------------------------------------------------------------
    logic [7:0] cnt_sync;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Resynchronise one bit of the asynchronous count.
            always_ff @(posedge clk or posedge reset_i) begin
                if (reset_i) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= cnt_i[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign cnt_sync[gi] = sync_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_reg,     state_next;
    logic [WINDOW_W-1:0]  timer_reg,     timer_next;
    logic [WINDOW_W-1:0]  window_reg,    window_next;
    logic [EXT_W-1:0]     wrap_reg,      wrap_next;
    logic                 wrap_ovf_reg,  wrap_ovf_next;
    logic                 msb_prev_reg,  msb_prev_next;
    logic [7:0]           prev_reg,      prev_next;
    logic                 cap_armed_reg, cap_armed_next;
    logic [3:0]           miss_reg,      miss_next;
    logic                 osc_reset_reg, osc_reset_next;
    logic                 osc_stop_reg,  osc_stop_next;
    logic                 busy_reg,      busy_next;
    logic                 valid_reg,     valid_next;
    logic [EXT_W+7:0]     result_reg,    result_next;
    logic                 overflow_reg,  overflow_next;

    logic msb_fall;
    assign msb_fall = msb_prev_reg & ~cnt_sync[7];

    // Register every piece of state; reset parks the oscillator.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            window_reg    <= '0;
            wrap_reg      <= '0;
            wrap_ovf_reg  <= 1'b0;
            msb_prev_reg  <= 1'b0;
            prev_reg      <= '0;
            cap_armed_reg <= 1'b0;
            miss_reg      <= '0;
            osc_reset_reg <= 1'b1;
            osc_stop_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            window_reg    <= window_next;
            wrap_reg      <= wrap_next;
            wrap_ovf_reg  <= wrap_ovf_next;
            msb_prev_reg  <= msb_prev_next;
            prev_reg      <= prev_next;
            cap_armed_reg <= cap_armed_next;
            miss_reg      <= miss_next;
            osc_reset_reg <= osc_reset_next;
            osc_stop_reg  <= osc_stop_next;
            busy_reg      <= busy_next;
            valid_reg     <= valid_next;
            result_reg    <= result_next;
            overflow_reg  <= overflow_next;
        end
    end

    // Next-state and next-output logic. Macro controls are computed one
    // cycle ahead so they are already correct in the state they belong to.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        window_next    = window_reg;
        wrap_next      = wrap_reg;
        wrap_ovf_next  = wrap_ovf_reg;
        msb_prev_next  = cnt_sync[7];
        prev_next      = prev_reg;
        cap_armed_next = cap_armed_reg;
        miss_next      = miss_reg;
        osc_reset_next = osc_reset_reg;
        osc_stop_next  = osc_stop_reg;
        busy_next      = busy_reg;
        valid_next     = 1'b0;
        result_next    = result_reg;
        overflow_next  = overflow_reg;

        // A falling MSB edge counts while running, and also during stop so
        // that an edge still inside the synchroniser is not lost.
        if ((state_reg == S_RUN || state_reg == S_STOP) && msb_fall) begin
            if (&wrap_reg) begin
                wrap_ovf_next = 1'b1;
            end else begin
                wrap_next = wrap_reg + 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                osc_reset_next = 1'b1;
                osc_stop_next  = 1'b1;
                if (start_i && (window_i != '0)) begin
                    window_next   = window_i;
                    timer_next    = CLR_LOAD;
                    wrap_next     = '0;
                    wrap_ovf_next = 1'b0;
                    busy_next     = 1'b1;
                    osc_stop_next = 1'b0;
                    state_next    = S_CLEAR;
                end
            end

            S_CLEAR: begin
                if (timer_reg == '0) begin
                    timer_next     = window_reg - 1'b1;
                    osc_reset_next = 1'b0;
                    state_next     = S_RUN;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            S_RUN: begin
                if (timer_reg == '0) begin
                    timer_next    = STOP_LOAD;
                    osc_stop_next = 1'b1;
                    state_next    = S_STOP;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            S_STOP: begin
                if (timer_reg == '0) begin
                    cap_armed_next = 1'b0;
                    miss_next      = '0;
                    state_next     = S_CAPTURE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end

            S_CAPTURE: begin
                if (!cap_armed_reg) begin
                    // First cycle only takes the reference sample.
                    prev_next      = cnt_sync;
                    cap_armed_next = 1'b1;
                end else if (cnt_sync == prev_reg || miss_reg == MISS_LAST) begin
                    // Stable word, or out of retries: publish what we have and
                    // flag an unsettled read as overflow.
                    result_next    = {wrap_reg, cnt_sync};
                    overflow_next  = wrap_ovf_reg | (cnt_sync != prev_reg);
                    valid_next     = 1'b1;
                    busy_next      = 1'b0;
                    osc_reset_next = 1'b1;
                    state_next     = S_IDLE;
                end else begin
                    prev_next = cnt_sync;
                    miss_next = miss_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign osc_reset_o = osc_reset_reg;
    assign osc_stop_o  = osc_stop_reg;
    assign busy_o      = busy_reg;
    assign valid_o     = valid_reg;
    assign result_o    = result_reg;
    assign overflow_o  = overflow_reg;

endmodule
